// File: rtl/sorter_pkg.sv
// sorter_pkg
//   Shared types and helpers for the bitonic sorter family (loader, sorter,
//   merger wrappers).
//   - loader_state_t : frame loader FSM states {FILL, PAD}
//   - SORT_*         : default geometry of a sorter frame
//   - frame_t        : SIZE-wide packed frame vector, slot 0 in the low bits
//   - pad_value()    : sentinel that sorts to the tail for a given direction
package sorter_pkg;

   typedef enum logic {
      FILL = 1'b0,
      PAD  = 1'b1
   } loader_state_t;

   localparam int SORT_VALUE_BITS = 8;
   localparam int SORT_DEPTH      = 3;
   localparam int SORT_SIZE       = 1 << SORT_DEPTH;

   typedef logic [SORT_SIZE-1:0][SORT_VALUE_BITS-1:0] frame_t;

   // Widest element the pad helper supports; callers slice to their width.
   localparam int PAD_MAX_BITS = 64;

   // Ascending sort (direction 0) pushes all-ones to the tail,
   // descending sort (direction 1) pushes all-zeros to the tail.
   function automatic logic [PAD_MAX_BITS-1:0] pad_value(input logic direction);
      return direction ? {PAD_MAX_BITS{1'b0}} : {PAD_MAX_BITS{1'b1}};
   endfunction

endpackage

// File: rtl/sort_frame_loader.sv
// sort_frame_loader
//   Collects a serial element stream into SIZE-wide frames for the bitonic
//   sorter. A frame ends on in_last or after SIZE elements; short frames are
//   padded with a direction-dependent sentinel so pads sort to the tail.
//
// Handshake: an element transfers on a rising clk edge where
//   in_valid && in_ready. in_ready is a function of FSM state (and rst_n)
//   only, never of in_valid. in_data/in_last are ignored unless accepted.
//   There is no downstream backpressure: out_valid is a one-cycle strobe.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   in_valid   upstream element valid
//   in_ready   loader accepts an element this cycle (high in FILL)
//   in_data    element value
//   in_last    final element of the frame, qualified by in_valid
//   out        registered frame, slot 0 = first-received element
//   out_valid  one-cycle strobe: out holds a new frame
//   out_count  number of real (non-pad) elements in out, 1..SIZE
//   dbg_state  current FSM state
module sort_frame_loader
   import sorter_pkg::*;
#(
   parameter int VALUE_BITS = 8,
   parameter int DEPTH      = 3,
   parameter bit DIRECTION  = 1'b0,
   parameter int SIZE       = 1 << DEPTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [VALUE_BITS-1:0]               in_data,
   input  logic                                in_last,
   output logic [SIZE-1:0][VALUE_BITS-1:0]     out,
   output logic                                out_valid,
   output logic [DEPTH:0]                      out_count,
   output loader_state_t                       dbg_state
);

   localparam logic [PAD_MAX_BITS-1:0] PAD_WIDE   = pad_value(DIRECTION);
   localparam logic [VALUE_BITS-1:0]   PAD_WORD   = PAD_WIDE[VALUE_BITS-1:0];
   localparam logic [DEPTH-1:0]        LAST_IDX   = DEPTH'(SIZE - 1);
   localparam logic [DEPTH:0]          FULL_COUNT = (DEPTH + 1)'(SIZE);

   loader_state_t                   state_q, state_d;
   logic [DEPTH-1:0]                idx_q, idx_d;
   logic [DEPTH:0]                  idx_inc;
   logic [DEPTH:0]                  count_q, count_d;
   logic [SIZE-1:0][VALUE_BITS-1:0] frame_buf_q;
   logic [SIZE-1:0][VALUE_BITS-1:0] frame_next;
   logic                            accept;
   logic                            wr_en;
   logic [VALUE_BITS-1:0]           wr_data;
   logic                            emit;
   logic [DEPTH:0]                  emit_count;

   assign in_ready  = rst_n && (state_q == FILL);
   assign accept    = in_valid && in_ready;
   assign idx_inc   = {1'b0, idx_q} + (DEPTH + 1)'(1);
   assign dbg_state = state_q;

   // Next state, slot write and emit decision.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      count_d    = count_q;
      wr_en      = 1'b0;
      wr_data    = in_data;
      emit       = 1'b0;
      emit_count = FULL_COUNT;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               wr_en = 1'b1;
               if (idx_q == LAST_IDX) begin
                  // Slot SIZE-1 closes the frame whether or not in_last is set.
                  emit       = 1'b1;
                  emit_count = FULL_COUNT;
                  idx_d      = '0;
               end else if (in_last) begin
                  count_d = idx_inc;
                  idx_d   = idx_inc[DEPTH-1:0];
                  state_d = PAD;
               end else begin
                  idx_d = idx_inc[DEPTH-1:0];
               end
            end
         end
         PAD: begin
            wr_en   = 1'b1;
            wr_data = PAD_WORD;
            if (idx_q == LAST_IDX) begin
               emit       = 1'b1;
               emit_count = count_q;
               idx_d      = '0;
               state_d    = FILL;
            end else begin
               idx_d = idx_inc[DEPTH-1:0];
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // Buffer as it will look after this edge; the emit edge publishes this
   // so the slot being written lands in out on the same edge.
   always_comb begin
      frame_next = frame_buf_q;
      if (wr_en) begin
         frame_next[idx_q] = wr_data;
      end
   end

   // Buffer contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      frame_buf_q <= frame_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FILL;
         idx_q     <= '0;
         count_q   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         out_count <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         out_valid <= emit;
         if (emit) begin
            out       <= frame_next;
            out_count <= emit_count;
         end
      end
   end

endmodule

// File: tb/tb_sort_frame_loader.sv
// tb_sort_frame_loader
//   Two loader instances (DIRECTION 0 and 1) share one input stream; every
//   emitted frame is compared against the padded frame the bench builds.
module tb_sort_frame_loader;
   import sorter_pkg::*;

   localparam int VB = 8;
   localparam int DP = 3;
   localparam int SZ = 8;
   // Expected record: {emit cycle[31:0], count[3:0], frame dir0[63:0], frame dir1[63:0]}
   localparam int EXP_W = 32 + 4 + 64 + 64;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    in_valid;
   logic [VB-1:0]           in_data;
   logic                    in_last;
   logic                    in_ready0, in_ready1;
   logic [SZ-1:0][VB-1:0]   out0, out1;
   logic                    out_valid0, out_valid1;
   logic [DP:0]             out_count0, out_count1;
   loader_state_t           dbg_state0, dbg_state1;

   int                      cyc = 0;
   int                      tests = 0;
   int                      fails = 0;
   int                      low_cnt = 0;

   logic [EXP_W-1:0]        exp_q[$];
   logic [31:0]             low_q[$];

   typedef struct {
      int         n;
      bit         last;
      logic [7:0] v [8];
      int         exp_count;
   } vec_t;

   vec_t vecs [5];

   sort_frame_loader #(.VALUE_BITS(VB), .DEPTH(DP), .DIRECTION(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_last(in_last), .out(out0), .out_valid(out_valid0),
      .out_count(out_count0), .dbg_state(dbg_state0)
   );

   sort_frame_loader #(.VALUE_BITS(VB), .DEPTH(DP), .DIRECTION(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_last(in_last), .out(out1), .out_valid(out_valid1),
      .out_count(out_count1), .dbg_state(dbg_state1)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running required finished");
      $fatal(1);
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      in_last  = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [7:0] v, input bit last, output int acc_cyc, output int waited);
      in_valid = 1'b1;
      in_data  = v;
      in_last  = last;
      waited   = 0;
      while (!in_ready0 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready0) check("in_ready timeout", {63'd0, in_ready0}, 64'd1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      idle_inputs();
   endtask

   task automatic send_frame(input int n, input bit last, input logic [7:0] v [8],
                             input int exp_count, output int first_cyc, output int last_cyc);
      int k, w;
      logic [63:0] f0, f1;
      first_cyc = 0;
      last_cyc  = 0;
      for (int i = 0; i < n; i++) begin
         send(v[i], last && (i == n - 1), k, w);
         if (i == 0) first_cyc = k;
         else check("in_ready held within frame", 64'(w), 64'd0);
      end
      last_cyc = k;
      for (int s = 0; s < SZ; s++) begin
         f0[8*s +: 8] = (s < n) ? v[s] : 8'hFF;
         f1[8*s +: 8] = (s < n) ? v[s] : 8'h00;
      end
      exp_q.push_back({32'(k + (SZ - n)), 4'(exp_count), f0, f1});
      if (n < SZ) low_q.push_back(32'(SZ - n));
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      logic [31:0]      lo;
      if (rst_n) begin
         check("in_ready dirs agree", {63'd0, in_ready1}, {63'd0, in_ready0});
         if (out_valid0 || out_valid1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected out_valid: got 1 required 0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               check("out_valid dir0", {63'd0, out_valid0}, 64'd1);
               check("out_valid dir1", {63'd0, out_valid1}, 64'd1);
               check("emit cycle", 64'(cyc), {32'd0, e[163:132]});
               check("out_count dir0", {60'd0, out_count0}, {60'd0, e[131:128]});
               check("out_count dir1", {60'd0, out_count1}, {60'd0, e[131:128]});
               check("out frame dir0", out0, e[127:64]);
               check("out frame dir1", out1, e[63:0]);
            end
         end
         if (!in_ready0) begin
            low_cnt++;
         end else if (low_cnt > 0) begin
            if (low_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected in_ready low: got %0d cycles required 0", low_cnt);
            end else begin
               lo = low_q.pop_front();
               check("in_ready low cycles", 64'(low_cnt), {32'd0, lo});
            end
            low_cnt = 0;
         end
      end else begin
         low_cnt = 0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int fc, lc, fc2, lc2, k, w, t;
      logic [7:0] vv [8];

      vecs[0].n = 8; vecs[0].last = 1'b0; vecs[0].exp_count = 8;
      vecs[0].v = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd4, 8'd8, 8'd2, 8'd6};
      vecs[1].n = 3; vecs[1].last = 1'b1; vecs[1].exp_count = 3;
      vecs[1].v = '{8'd5, 8'd1, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      vecs[2].n = 8; vecs[2].last = 1'b1; vecs[2].exp_count = 8;
      vecs[2].v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      vecs[3].n = 5; vecs[3].last = 1'b1; vecs[3].exp_count = 5;
      vecs[4].n = 8; vecs[4].last = 1'b0; vecs[4].exp_count = 8;
      for (int i = 0; i < 8; i++) begin
         vecs[3].v[i] = 8'($urandom_range(1, 254));
         vecs[4].v[i] = 8'($urandom_range(0, 255));
      end

      // Reset held for 3 cycles.
      rst_n = 1'b0;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset out", out0 | out1, 64'd0);
         check("reset out_valid", {62'd0, out_valid0, out_valid1}, 64'd0);
         check("reset out_count", {56'd0, out_count0, out_count1}, 64'd0);
         check("reset in_ready", {62'd0, in_ready0, in_ready1}, 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready after reset", {62'd0, in_ready0, in_ready1}, 64'd3);
      @(posedge clk); #1;

      // Table-driven frames with random idle gaps.
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].n, vecs[i].last, vecs[i].v, vecs[i].exp_count, fc, lc);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      // Back-to-back: 1-element frame then a full frame with no gap.
      vv = '{8'h42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      send_frame(1, 1'b1, vv, 1, fc, lc);
      vv = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
      send_frame(8, 1'b0, vv, 8, fc2, lc2);
      check("b2b first accept in out_valid cycle", 64'(fc2), 64'(lc + 8));
      repeat (2) begin @(posedge clk); #1; end

      // Reset mid-frame: 4 elements dropped, no emit, next frame from slot 0.
      for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 1'b0, k, w);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid-frame reset out", out0 | out1, 64'd0);
      check("mid-frame reset out_count", {56'd0, out_count0, out_count1}, 64'd0);
      @(posedge clk); #1;
      vv = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      send_frame(8, 1'b0, vv, 8, fc, lc);

      // Drain outstanding expectations.
      t = 0;
      while ((exp_q.size() != 0 || low_q.size() != 0) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("pending frames at end", 64'(exp_q.size()), 64'd0);
      check("pending ready windows at end", 64'(low_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sort_frame_loader.md
Name: sort_frame_loader

Overview:
- Upstream feeder for the bitonic `sorter`.
- Accepts a serial stream of values over a valid/ready handshake. Each frame ends with `in_last` or when SIZE elements have arrived.
- Short frames are padded with a direction-dependent sentinel, so pads always sort to the tail of the output.
- Each completed frame is presented as one registered SIZE-wide vector with a single-cycle `out_valid` strobe, wired directly to `sorter.in`.

Parameters:
- VALUE_BITS, 8, width of one element; must match the sorter.
- DEPTH, 3, log2 of frame size; must match the sorter.
- DIRECTION, 0, sort direction of the downstream sorter. 0: pad value all-ones. 1: pad value all-zeros.
- SIZE, 1 << DEPTH, derived; do not override.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  loader can accept an element this cycle.
- in_data  in  VALUE_BITS  element value.
- in_last  in  1  final element of the frame; qualified by in_valid.
- out  out  [SIZE-1:0][VALUE_BITS-1:0]  registered frame. Slot 0 is the first-received element. Connects to `sorter.in`.
- out_valid  out  1  one-cycle strobe: `out` holds a new frame.
- out_count  out  DEPTH+1  number of real (non-pad) elements in `out`, range 1..SIZE.

Behaviour:
- Accept condition: in_valid && in_ready on the clock edge.
- Internal state: slot index `idx` (DEPTH bits), frame buffer `buf` (SIZE x VALUE_BITS), FSM {FILL, PAD}.
- Reset (rst_n low at an edge):
  - state=FILL, idx=0, out=0, out_valid=0, out_count=0.
  - Any partial frame is discarded; buf contents are don't-care.
  - in_ready=0 while rst_n is low.
- FILL:
  - in_ready=1.
  - On accept, write in_data to buf[idx].
  - idx==SIZE-1 (regardless of in_last): emit with count SIZE. Set idx=0 and stay in FILL.
  - Else if in_last: latch count=idx+1, idx=idx+1, go to PAD.
  - Else: idx=idx+1.
- PAD:
  - in_ready=0.
  - Each cycle write the pad value to buf[idx].
  - idx==SIZE-1: emit with the latched count, idx=0, go to FILL.
  - Else: idx=idx+1.
- Emit (on the edge that writes slot SIZE-1):
  - `out` is loaded with the complete frame, including the slot being written that edge.
  - out_valid=1 for exactly the following cycle. out_count is updated on the same edge.
  - `out` and out_count hold their value until the next emit. out_valid returns to 0 otherwise.
- Latency:
  - Full frame: out_valid asserts the cycle after the 8th/SIZE-th accept.
  - Frame of n<SIZE elements: in_ready is low for SIZE-n cycles after the last accept. out_valid asserts the cycle after the final PAD cycle.
- Back-to-back operation:
  - In the cycle out_valid is high, the FSM is already in FILL with in_ready=1.
  - A new frame's first element may be accepted there with zero bubble.
- Upstream ready dependency: in_ready depends only on FSM state, with no combinational path from in_valid.
- Inputs outside the accept condition: in_data and in_last are ignored when not accepted, including while in PAD.
- Frame length: zero-length frames are impossible, since in_last is valid-qualified.
- No downstream backpressure: the sorter always accepts.

Decomposition:
- Shared package `sorter_pkg`:
  - `loader_state_t` enum {FILL, PAD}.
  - Function `pad_value(direction)` returning all-ones or all-zeros at VALUE_BITS width.
  - Localparam/typedef for the frame vector type `[SIZE-1:0][VALUE_BITS-1:0]`, reused by sorter/merger wrappers.
- No sub-module; a single FSM, counter and buffer in one module of about 150 lines.

Test Plan (VALUE_BITS=8, DEPTH=3, SIZE=8):
1. Reset check: hold rst_n=0 for 3 cycles, then release. Required: out=0, out_valid=0, out_count=0, in_ready=0 during reset and 1 in the first cycle after.
2. Full frame: send 7,3,9,1,4,8,2,6 on consecutive cycles, no in_last. Required:
   - in_ready stays 1 throughout.
   - out_valid=1 the cycle after the 8th accept, for 1 cycle.
   - out[0..7]=7,3,9,1,4,8,2,6; out_count=8.
3. Short frame, DIRECTION=0: send 5,1,9 with in_last on 9. Required:
   - in_ready=0 for exactly 5 cycles.
   - out=5,1,9,FF,FF,FF,FF,FF; out_count=3.
   - Downstream sorter then yields 1,5,9,FF... .
4. Short frame, DIRECTION=1: send 5,1,9 with in_last on 9. Required: out=5,1,9,00,00,00,00,00; out_count=3.
5. Back-to-back frames: a 1-element frame (value 0x42, last), immediately followed by 8 elements 10..17 with in_valid held high. Required:
   - in_ready low for 7 cycles.
   - First emit: out[0]=42, out_count=1.
   - Value 10 accepted in the first emit's out_valid cycle.
   - Second emit: out=10..17, out_count=8.
6. Edge cases, each checked separately:
   - in_last on the 8th element: no PAD cycles, out_count=8.
   - Reset mid-frame: send 4 elements, then pulse rst_n low for 1 cycle. Required: no out_valid; the next 8 elements emit starting at slot 0.
